// File: rtl/pwm_capture.sv
// Measures period/high time of an async PWM input between rising edges and derives a duty code.
// Result appears DUTY_W+1 cycles after the closing rise; a rise arriving while the divider is busy is dropped (ovr).
module pwm_capture #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              ovr
);

  localparam int DC_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

  typedef enum logic {IDLE, MEAS} state_t;

  state_t            state, state_nxt;
  logic              sync1, pwm_s, pwm_p;
  logic              rise;
  logic [CNT_W-1:0]  per_ctr, hi_ctr;
  logic [CNT_W-1:0]  p_lat, h_lat;
  logic [CNT_W:0]    rem, rem_sh, rem_nxt;
  logic [DUTY_W-1:0] q, q_nxt;
  logic [DC_W-1:0]   div_cnt;
  logic              div_busy, div_last, div_free, ge;
  logic              accept, drop, timeout;

  assign rise = pwm_s & ~pwm_p;

  // One restoring-division step; rem < P always, so the shift never loses a set bit.
  assign rem_sh   = rem << 1;
  assign ge       = rem_sh >= {1'b0, p_lat};
  assign rem_nxt  = ge ? (rem_sh - {1'b0, p_lat}) : rem_sh;
  assign q_nxt    = {q[DUTY_W-2:0], ge};
  assign div_last = div_busy && (div_cnt == DC_W'(DUTY_W - 1));
  assign div_free = !div_busy || div_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_p <= 1'b0;
      state <= IDLE;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_p <= pwm_s;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = MEAS;
      MEAS: begin
        if (rise) begin
          accept = div_free;
          drop   = !div_free;
        end else if (per_ctr == '1) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_ctr   <= '0;
      hi_ctr    <= '0;
      p_lat     <= '0;
      h_lat     <= '0;
      rem       <= '0;
      q         <= '0;
      div_cnt   <= '0;
      div_busy  <= 1'b0;
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      valid <= 1'b0;
      ovr   <= drop;

      if (rise) begin
        per_ctr <= CNT_W'(1);
        hi_ctr  <= CNT_W'(1);
      end else if (state == MEAS) begin
        per_ctr <= per_ctr + CNT_W'(1);
        hi_ctr  <= hi_ctr + CNT_W'(pwm_s);
      end

      if (div_busy) begin
        rem     <= rem_nxt;
        q       <= q_nxt;
        div_cnt <= div_cnt + DC_W'(1);
      end

      if (div_last) begin
        period    <= p_lat;
        high_time <= h_lat;
        duty      <= q_nxt;
        valid     <= 1'b1;
        stuck     <= 1'b0;
        div_busy  <= 1'b0;
      end

      // Placed after completion so a rise in the completing cycle restarts the divider.
      if (accept) begin
        p_lat    <= per_ctr;
        h_lat    <= hi_ctr;
        rem      <= {1'b0, hi_ctr};
        q        <= '0;
        div_cnt  <= '0;
        div_busy <= 1'b1;
      end

      if (timeout) begin
        div_busy  <= 1'b0;
        period    <= '0;
        high_time <= '0;
        duty      <= {DUTY_W{pwm_s}};
        valid     <= 1'b1;
        stuck     <= 1'b1;
      end
    end
  end

endmodule
